// File: rtl/conv_mac_seq.sv
// Sequencer for one convolution output: walks KLEN act/wgt pairs through a shared
// mult_add primitive, feeds the clamped running sum back as C, and hands off the 33-bit result.
module conv_mac_seq #(
    parameter int KLEN    = 25,
    parameter int ADDR_W  = 5,
    parameter int MAC_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [27:0]       bias,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       act_data,
    input  logic [15:0]       wgt_data,
    output logic              mac_en,
    output logic              mac_sclr,
    output logic [15:0]       mac_a,
    output logic [15:0]       mac_b,
    output logic [27:0]       mac_c,
    input  logic [32:0]       mac_p,
    output logic [32:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sat_flag
);

    // state   | meaning
    // IDLE    | waiting for start; bias captured on accept
    // READ    | BRAM read of term k
    // LOAD    | register act/wgt/acc into mult_add operands
    // EXEC    | mac_en high for MAC_LAT clocks, operands held
    // CAPTURE | sample P; feed back clamped sum or finish
    // OUT     | result valid, waiting for out_ready
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_EXEC,
        S_CAPTURE,
        S_OUT
    } state_t;

    localparam int                CNT_W    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MAC_LAT - 1);
    localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(KLEN - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_k;
    logic [27:0]       r_acc;
    logic [15:0]       r_mac_a;
    logic [15:0]       r_mac_b;
    logic [27:0]       r_mac_c;
    logic [32:0]       r_out_data;
    logic              r_sat;

    logic              w_accept;
    logic              w_last;
    logic              w_ovf;
    logic [27:0]       w_p_sat;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_k == K_LAST);

    // P fits in 28 bits only if its top six bits are all copies of the sign
    assign w_ovf    = ~((&mac_p[32:27]) | ~(|mac_p[32:27]));
    assign w_p_sat  = w_ovf ? (mac_p[32] ? 28'h800_0000 : 28'h7FF_FFFF) : mac_p[27:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_READ;
            S_READ:    w_state_nxt = S_LOAD;
            S_LOAD:    w_state_nxt = S_EXEC;
            S_EXEC:    if (r_cnt == '0) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = w_last ? S_OUT : S_READ;
            S_OUT:     if (out_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            r_mac_a    <= '0;
            r_mac_b    <= '0;
            r_mac_c    <= '0;
            r_out_data <= '0;
            r_sat      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc <= bias;
                        r_sat <= 1'b0;
                        r_k   <= '0;
                    end
                end
                S_LOAD: begin
                    r_mac_a <= act_data;
                    r_mac_b <= wgt_data;
                    r_mac_c <= r_acc;
                    r_cnt   <= CNT_LOAD;
                end
                S_EXEC: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                S_CAPTURE: begin
                    // the final sum leaves unclamped; only the C feedback is saturated
                    if (w_last) begin
                        r_out_data <= mac_p;
                    end else begin
                        r_acc <= w_p_sat;
                        r_k   <= r_k + 1'b1;
                        if (w_ovf) r_sat <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign rd_en     = (r_state == S_READ);
    assign rd_addr   = r_k;
    assign mac_en    = (r_state == S_EXEC);
    assign mac_sclr  = rst | w_accept;
    assign mac_a     = r_mac_a;
    assign mac_b     = r_mac_b;
    assign mac_c     = r_mac_c;
    assign out_data  = r_out_data;
    assign out_valid = (r_state == S_OUT);
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_conv_mac_seq.sv
// Directed bench for conv_mac_seq: default build plus a KLEN=1/MAC_LAT=1 build,
// each with a behavioural BRAM pair and mult_add pipeline.
module tb_conv_mac_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst, start, busy, rd_en, mac_en, mac_sclr, out_valid, out_ready, sat_flag;
    logic [27:0] bias, mac_c;
    logic [4:0]  rd_addr;
    logic [15:0] act_data, wgt_data, mac_a, mac_b;
    logic [32:0] mac_p, out_data;

    logic        start_s, busy_s, rd_en_s, mac_en_s, mac_sclr_s, out_valid_s, out_ready_s, sat_flag_s;
    logic [27:0] bias_s, mac_c_s;
    logic [4:0]  rd_addr_s;
    logic [15:0] act_data_s, wgt_data_s, mac_a_s, mac_b_s;
    logic [32:0] mac_p_s, out_data_s;

    conv_mac_seq dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .act_data(act_data), .wgt_data(wgt_data),
        .mac_en(mac_en), .mac_sclr(mac_sclr), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
        .mac_p(mac_p), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sat_flag(sat_flag)
    );

    conv_mac_seq #(.KLEN(1), .ADDR_W(5), .MAC_LAT(1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .bias(bias_s), .busy(busy_s),
        .rd_en(rd_en_s), .rd_addr(rd_addr_s), .act_data(act_data_s), .wgt_data(wgt_data_s),
        .mac_en(mac_en_s), .mac_sclr(mac_sclr_s), .mac_a(mac_a_s), .mac_b(mac_b_s), .mac_c(mac_c_s),
        .mac_p(mac_p_s), .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
        .sat_flag(sat_flag_s)
    );

    function automatic logic signed [32:0] mul_add(input logic [15:0] a, input logic [15:0] b,
                                                   input logic [27:0] c);
        logic signed [32:0] sa, sb, sc;
        sa = {{17{a[15]}}, a};
        sb = {{17{b[15]}}, b};
        sc = {{5{c[27]}}, c};
        return sa * sb + sc;
    endfunction

    // BRAMs (1-cycle read latency)
    logic [15:0] act_mem [0:31];
    logic [15:0] wgt_mem [0:31];
    logic [15:0] act_s0, wgt_s0;
    always @(posedge clk) begin
        if (rd_en === 1'b1) begin
            act_data <= act_mem[rd_addr];
            wgt_data <= wgt_mem[rd_addr];
        end
        if (rd_en_s === 1'b1) begin
            act_data_s <= (rd_addr_s == 5'd0) ? act_s0 : 16'h0;
            wgt_data_s <= (rd_addr_s == 5'd0) ? wgt_s0 : 16'h0;
        end
    end

    // mult_add models: P valid after MAC_LAT CE clocks, SCLR clears the pipeline
    logic signed [32:0] pipe [0:2];
    logic signed [32:0] pipe_s;
    always @(posedge clk) begin
        if (mac_sclr === 1'b1) begin
            pipe[0] <= '0; pipe[1] <= '0; pipe[2] <= '0;
        end else if (mac_en === 1'b1) begin
            pipe[0] <= mul_add(mac_a, mac_b, mac_c);
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        if (mac_sclr_s === 1'b1)   pipe_s <= '0;
        else if (mac_en_s === 1'b1) pipe_s <= mul_add(mac_a_s, mac_b_s, mac_c_s);
    end
    assign mac_p   = pipe[2];
    assign mac_p_s = pipe_s;

    int addr_log[$];
    int en_cnt_s = 0;
    always @(posedge clk) begin
        if (rd_en === 1'b1) addr_log.push_back(int'(rd_addr));
        if (mac_en_s === 1'b1) en_cnt_s <= en_cnt_s + 1;
    end

    task automatic load_mem(input int mode);
        for (int i = 0; i < 32; i++) begin
            case (mode)
                0:       begin act_mem[i] = 16'd1;     wgt_mem[i] = 16'd1;     end
                1:       begin act_mem[i] = 16'(i);    wgt_mem[i] = 16'hFFFE;  end
                default: begin act_mem[i] = 16'd32767; wgt_mem[i] = 16'd32767; end
            endcase
        end
    endtask

    task automatic start_job(input logic [27:0] b);
        @(negedge clk);
        bias  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // returns the cycle (edge of start accept = 0) in which out_valid first reads high, -1 on timeout
    task automatic wait_valid(output int cyc);
        int n = 0;
        while (out_valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        cyc = (out_valid === 1'b1) ? n + 1 : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bias = '0; out_ready = 1'b0;
        start_s = 1'b0; bias_s = '0; out_ready_s = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (mac_sclr !== 1'b1) begin
            errors++; $display("FAIL reset_sclr got %b want 1", mac_sclr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, rd_en, rd_addr, mac_en, mac_sclr, mac_a, mac_b, mac_c, out_data, out_valid, sat_flag} !== 104'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b rd_en=%b addr=%0d en=%b sclr=%b a=%h b=%h c=%h out=%h v=%b sat=%b want all 0",
                     busy, rd_en, rd_addr, mac_en, mac_sclr, mac_a, mac_b, mac_c, out_data, out_valid, sat_flag);
        end
    endtask

    task automatic test_ones();
        int cyc, base;
        bit ok;
        load_mem(0);
        out_ready = 1'b1;
        base = addr_log.size();
        start_job(28'd0);
        wait_valid(cyc);
        checks++;
        if (cyc != 151) begin errors++; $display("FAIL ones_latency got %0d want 151", cyc); end
        checks++;
        if (out_data !== 33'd25) begin errors++; $display("FAIL ones_data got %0d want 25", $signed(out_data)); end
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL ones_sat got %b want 0", sat_flag); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL ones_handshake got valid=%b busy=%b want 0 0", out_valid, busy);
        end
        ok = (addr_log.size() - base == 25);
        for (int i = 0; i < 25 && ok; i++) if (addr_log[base + i] != i) ok = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL ones_addr_seq got %0d reads want 0..24 in order", addr_log.size() - base); end
    endtask

    task automatic test_signed();
        int cyc;
        load_mem(1);
        out_ready = 1'b1;
        start_job(-28'sd100);
        wait_valid(cyc);
        checks++;
        if (out_data !== -33'sd700) begin errors++; $display("FAIL signed_data got %0d want -700", $signed(out_data)); end
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL signed_sat got %b want 0", sat_flag); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int cyc;
        load_mem(2);
        out_ready = 1'b1;
        start_job(28'd0);
        wait_valid(cyc);
        checks++;
        if (out_data !== 33'd1207894016) begin errors++; $display("FAIL sat_data got %0d want 1207894016", $signed(out_data)); end
        checks++;
        if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag got %b want 1", sat_flag); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc;
        load_mem(0);
        out_ready = 1'b0;
        start_job(28'd0);
        wait_valid(cyc);
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL bp_sat_cleared got %b want 0", sat_flag); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = (i == 3);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 33'd25 || busy !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d] got valid=%b data=%0d busy=%b want 1 25 1", i, out_valid, $signed(out_data), busy);
            end
        end
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_release got valid=%b busy=%b want 0 0", out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_start_ignored got busy=%b want 0", busy); end
        load_mem(1);
        out_ready = 1'b1;
        start_job(28'd7);
        wait_valid(cyc);
        checks++;
        if (out_data !== -33'sd593 || cyc != 151) begin
            errors++; $display("FAIL bp_second_job got %0d at cycle %0d want -593 at 151", $signed(out_data), cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midjob();
        int n, cyc;
        bit seen;
        load_mem(0);
        out_ready = 1'b1;
        start_job(28'd0);
        n = 0;
        while (!(rd_addr === 5'd7 && mac_en === 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin errors++; $display("FAIL mid_reach_exec7 got timeout want EXEC of term 7"); end
        rst = 1'b1;
        #1;
        checks++;
        if (mac_sclr !== 1'b1) begin errors++; $display("FAIL mid_sclr got %b want 1", mac_sclr); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, rd_en, rd_addr, mac_en, mac_sclr, mac_a, mac_b, mac_c, out_data, out_valid, sat_flag} !== 104'd0) begin
            errors++;
            $display("FAIL mid_outputs got busy=%b rd_en=%b addr=%0d en=%b a=%h b=%h c=%h out=%h v=%b want all 0",
                     busy, rd_en, rd_addr, mac_en, mac_a, mac_b, mac_c, out_data, out_valid);
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL mid_discard got activity after reset want idle"); end
        start_job(28'd0);
        wait_valid(cyc);
        checks++;
        if (out_data !== 33'd25 || cyc != 151) begin
            errors++; $display("FAIL mid_fresh_job got %0d at cycle %0d want 25 at 151", $signed(out_data), cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_small_config();
        int n, e0;
        act_s0 = 16'd3;
        wgt_s0 = 16'd4;
        out_ready_s = 1'b1;
        e0 = en_cnt_s;
        @(negedge clk);
        bias_s  = 28'd5;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        n = 0;
        while (out_valid_s !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid_s !== 1'b1 || n + 1 != 5) begin
            errors++; $display("FAIL small_latency got valid=%b cycle %0d want 1 at 5", out_valid_s, n + 1);
        end
        checks++;
        if (out_data_s !== 33'd17 || sat_flag_s !== 1'b0) begin
            errors++; $display("FAIL small_data got %0d sat=%b want 17 0", $signed(out_data_s), sat_flag_s);
        end
        @(negedge clk);
        checks++;
        if (en_cnt_s - e0 != 1 || busy_s !== 1'b0) begin
            errors++; $display("FAIL small_mac_en got %0d cycles busy=%b want 1 0", en_cnt_s - e0, busy_s);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_signed();
        test_saturation();
        test_back_to_back();
        test_reset_midjob();
        test_small_config();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got no completion want finish before 1ms");
        $fatal(1, "watchdog");
    end

endmodule
